urv_wb_stage: RTL

URV_WB_STAGE -- requirements
Module: urv_wb_stage

---
 rtl/urv_wb_stage.sv | 134 +++++++++++++
 1 files changed

// File: rtl/urv_wb_stage.sv
// Writeback stage: holds one retiring instruction, formats load data and
// stalls the pipe until a pending load returns its data.
module urv_wb_stage (
   input  logic        clk_i,
   input  logic        rst_i,

   input  logic        x_valid_i,
   input  logic [4:0]  x_rd_i,
   input  logic        x_rd_write_i,
   input  logic [1:0]  x_rd_source_i,
   input  logic [31:0] x_rd_value_i,
   input  logic [2:0]  x_fun_i,
   input  logic [1:0]  x_dm_addr_i,

   input  logic [31:0] dm_data_l_i,
   input  logic        dm_load_done_i,
   input  logic [31:0] mul_result_i,

   output logic        w_stall_o,
   output logic [4:0]  w_rd_o,
   output logic [31:0] w_rd_value_o,
   output logic        w_rd_store_o,
   output logic        w_bypass_rd_write_o,
   output logic [31:0] w_bypass_rd_value_o,
   output logic        w_load_hazard_o
);

   localparam logic [1:0] SRC_ALU  = 2'd0;
   localparam logic [1:0] SRC_LOAD = 2'd1;
   localparam logic [1:0] SRC_MUL  = 2'd2;

   typedef enum logic {
      IDLE,
      WAIT_LOAD
   } state_t;

   state_t      state_q, state_d;

   logic        valid_q;
   logic [4:0]  rd_q;
   logic        rd_write_q;
   logic [1:0]  source_q;
   logic [31:0] value_q;
   logic [2:0]  fun_q;
   logic [1:0]  addr_q;

   logic        is_load;
   logic        stall;
   logic [7:0]  load_byte;
   logic [15:0] load_half;
   logic [31:0] load_value;

   assign is_load = valid_q && (source_q == SRC_LOAD);
   assign stall   = is_load && !dm_load_done_i;

   // The reserved source encoding is folded to ALU at capture so every
   // downstream decode only ever sees three legal values.
   // NOTE: sequential state uses non-blocking assignments so all flops
   // sample the pre-edge values regardless of statement order.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         valid_q    <= 1'b0;
         rd_q       <= '0;
         rd_write_q <= 1'b0;
         source_q   <= SRC_ALU;
         value_q    <= '0;
         fun_q      <= '0;
         addr_q     <= '0;
      end else begin
         state_q <= state_d;
         if (!stall) begin
            valid_q <= x_valid_i;
            if (x_valid_i) begin
               rd_q       <= x_rd_i;
               rd_write_q <= x_rd_write_i;
               source_q   <= (x_rd_source_i == 2'd3) ? SRC_ALU : x_rd_source_i;
               value_q    <= x_rd_value_i;
               fun_q      <= x_fun_i;
               addr_q     <= x_dm_addr_i;
            end
         end
      end
   end

   // NOTE: state_d gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (stall)          state_d = WAIT_LOAD;
         WAIT_LOAD: if (dm_load_done_i) state_d = IDLE;
         default:                       state_d = IDLE;
      endcase
   end

   always_comb begin
      load_byte = dm_data_l_i[7:0];
      case (addr_q)
         2'd0:    load_byte = dm_data_l_i[7:0];
         2'd1:    load_byte = dm_data_l_i[15:8];
         2'd2:    load_byte = dm_data_l_i[23:16];
         default: load_byte = dm_data_l_i[31:24];
      endcase
      load_half = addr_q[1] ? dm_data_l_i[31:16] : dm_data_l_i[15:0];

      load_value = dm_data_l_i;
      case (fun_q)
         3'b000:  load_value = {{24{load_byte[7]}}, load_byte};
         3'b100:  load_value = {24'h0, load_byte};
         3'b001:  load_value = {{16{load_half[15]}}, load_half};
         3'b101:  load_value = {16'h0, load_half};
         default: load_value = dm_data_l_i;
      endcase
   end

   always_comb begin
      w_rd_value_o = value_q;
      case (source_q)
         SRC_LOAD: w_rd_value_o = load_value;
         SRC_MUL:  w_rd_value_o = mul_result_i;
         default:  w_rd_value_o = value_q;
      endcase
   end

   assign w_stall_o           = stall;
   assign w_rd_o              = rd_q;
   assign w_rd_store_o        = valid_q && rd_write_q &&
                                ((source_q != SRC_LOAD) || dm_load_done_i);
   assign w_bypass_rd_write_o = valid_q && rd_write_q && (source_q == SRC_ALU);
   assign w_bypass_rd_value_o = value_q;
   assign w_load_hazard_o     = valid_q && rd_write_q && (source_q == SRC_LOAD);

endmodule
